// File: rtl/div_ctrl.sv
// div_ctrl: multicycle 32-bit restoring divider for DIV/DIVU with pipeline stall control.
// Quotient to lo_out and remainder to hi_out; divide-by-zero short-circuits through ZERO.
module div_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        startE,
   input  logic        signedE,
   input  logic [31:0] srcaE,
   input  logic [31:0] srcbE,
   input  logic        cancel,
   output logic        div_stall,
   output logic        div_done,
   output logic        div_zero,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);
   typedef enum logic [1:0] {IDLE, BUSY, ZERO, DONE} state_t;
   state_t r_state, w_next;
   logic [4:0]  r_cnt;
   logic [31:0] r_quo, r_rem, r_div, r_hi, r_lo;
   logic        r_neg_q, r_neg_r, r_zero;
   logic [31:0] w_a_mag, w_b_mag, w_q_nx, w_r_nx;
   logic [32:0] w_sh, w_diff;
   logic        w_start;

   assign w_start = r_state == IDLE && startE;
   assign w_a_mag = signedE && srcaE[31] ? -srcaE : srcaE;
   assign w_b_mag = signedE && srcbE[31] ? -srcbE : srcbE;
   // r_quo starts as the dividend magnitude and shifts quotient bits in from the right
   assign w_sh    = {r_rem, r_quo[31]};
   assign w_diff  = w_sh - {1'b0, r_div};
   assign w_q_nx  = {r_quo[30:0], ~w_diff[32]};
   assign w_r_nx  = w_diff[32] ? w_sh[31:0] : w_diff[31:0];

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = startE ? (srcbE == 32'd0 ? ZERO : BUSY) : IDLE;
         BUSY:    w_next = cancel ? IDLE : (r_cnt == 5'd31 ? DONE : BUSY);
         ZERO:    w_next = cancel ? IDLE : DONE;
         default: w_next = IDLE;
      endcase
   end

   assign div_stall = w_start || r_state == BUSY || r_state == ZERO;
   assign div_done  = r_state == DONE;
   assign div_zero  = r_zero;
   assign hi_out    = r_hi;
   assign lo_out    = r_lo;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 5'd0;
         r_quo   <= 32'd0;
         r_rem   <= 32'd0;
         r_div   <= 32'd0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
         r_zero  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_cnt   <= 5'd0;
            r_quo   <= srcbE == 32'd0 ? srcaE : w_a_mag;
            r_rem   <= 32'd0;
            r_div   <= w_b_mag;
            r_neg_q <= signedE && (srcaE[31] ^ srcbE[31]);
            r_neg_r <= signedE && srcaE[31];
         end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + 5'd1;
            r_quo <= w_q_nx;
            r_rem <= w_r_nx;
         end
         // results are loaded on entry to DONE so they are valid during the div_done pulse
         if (w_next == DONE) begin
            r_zero <= r_state == ZERO;
            r_lo   <= r_state == ZERO ? 32'hFFFF_FFFF : (r_neg_q ? -w_q_nx : w_q_nx);
            r_hi   <= r_state == ZERO ? r_quo : (r_neg_r ? -w_r_nx : w_r_nx);
         end
      end
endmodule
